// File: rtl/p2m_pkg.sv
// p2m_pkg: shared widths, message layout and helpers for the pipe-to-method dispatcher
package p2m_pkg;
   localparam int SEL_W_DEF = 16;
   localparam int PAYLOAD_W_DEF = 128;
   localparam int ERR_W = 16;
   typedef struct packed {
      logic [SEL_W_DEF-1:0] sel;
      logic [PAYLOAD_W_DEF-1:0] payload;
   } msg_t;
   typedef enum logic {RUN, TRAP} trap_state_t;
   function automatic logic [ERR_W-1:0] sat_inc(input logic [ERR_W-1:0] v);
      return &v ? v : v + ERR_W'(1);
   endfunction
endpackage

// File: rtl/p2m_if.sv
// p2m_if: enq pipe, method ENA/RDY bus and status of the dispatcher
interface p2m_if
   import p2m_pkg::*;
#(
   parameter int NUM_METHODS = 2,
   parameter int SEL_W = SEL_W_DEF,
   parameter int PAYLOAD_W = PAYLOAD_W_DEF,
   parameter int DEPTH = 4
);
   localparam int MSG_W = SEL_W + PAYLOAD_W;
   localparam int CNT_W = $clog2(DEPTH + 1);
   logic pipe_enq_ena;
   logic [MSG_W-1:0] pipe_enq_v;
   logic pipe_enq_rdy;
   logic [NUM_METHODS-1:0] method_ena;
   logic [NUM_METHODS-1:0] method_rdy;
   logic [PAYLOAD_W-1:0] method_data;
   logic err_unknown;
   logic [ERR_W-1:0] err_count;
   logic [CNT_W-1:0] occupancy;
   modport slave(
      input pipe_enq_ena, pipe_enq_v, method_rdy,
      output pipe_enq_rdy, method_ena, method_data, err_unknown, err_count, occupancy
   );
   modport master(
      output pipe_enq_ena, pipe_enq_v, method_rdy,
      input pipe_enq_rdy, method_ena, method_data, err_unknown, err_count, occupancy
   );
endinterface

// File: rtl/p2m_fifo.sv
// p2m_fifo: DEPTH x W synchronous FIFO with fill count; DEPTH must be a power of two
module p2m_fifo #(
   parameter int W = 144,
   parameter int DEPTH = 4,
   localparam int CNT_W = $clog2(DEPTH + 1),
   localparam int AW = $clog2(DEPTH)
) (
   input logic clk,
   input logic rst,
   input logic push,
   input logic pop,
   input logic [W-1:0] din,
   output logic [W-1:0] dout,
   output logic [CNT_W-1:0] count,
   output logic full,
   output logic empty
);
   logic [W-1:0] mem [DEPTH];
   logic [AW-1:0] wp, rp;
   always_ff @(posedge clk) begin
      if (rst) begin
         wp <= '0;
         rp <= '0;
         count <= '0;
      end else begin
         if (push) begin
            mem[wp] <= din;
            wp <= wp + AW'(1);
         end
         if (pop) rp <= rp + AW'(1);
         count <= count + CNT_W'(push) - CNT_W'(pop);
      end
   end
   assign dout = mem[rp];
   assign full = count == CNT_W'(DEPTH);
   assign empty = count == '0;
endmodule

// File: rtl/p2m_dispatch.sv
// p2m_dispatch: buffers selector+payload messages and dispatches them in order to ENA/RDY method ports.
// Define P2M_UNKNOWN_TRAP_EN to halt on an unknown selector instead of discarding it.
module p2m_dispatch
   import p2m_pkg::*;
#(
   parameter int NUM_METHODS = 2,
   parameter int SEL_W = SEL_W_DEF,
   parameter int PAYLOAD_W = PAYLOAD_W_DEF,
   parameter int DEPTH = 4
) (
   input logic CLK,
   input logic nRST,
   p2m_if.slave bus
);
   localparam int MSG_W = SEL_W + PAYLOAD_W;
   localparam int CNT_W = $clog2(DEPTH + 1);
   localparam logic [SEL_W:0] NM = (SEL_W + 1)'(NUM_METHODS);
   logic [MSG_W-1:0] head;
   logic [CNT_W-1:0] count;
   logic [SEL_W-1:0] sel;
   logic [NUM_METHODS-1:0] ena;
   logic [ERR_W-1:0] err_cnt;
   logic full, empty, push, pop, known, bad, go, err_evt;
   p2m_fifo #(.W(MSG_W), .DEPTH(DEPTH)) u_fifo (
      .clk(CLK), .rst(nRST), .push(push), .pop(pop), .din(bus.pipe_enq_v),
      .dout(head), .count(count), .full(full), .empty(empty)
   );
   assign sel = head[MSG_W-1:PAYLOAD_W];
   assign known = {1'b0, sel} < NM;
   // nothing leaves the FIFO in a reset cycle
   assign go = !empty && known && !nRST;
   assign bad = !empty && !known && !nRST;
   assign ena = (NUM_METHODS'(1) << sel) & bus.method_rdy & {NUM_METHODS{go}};
   assign push = bus.pipe_enq_ena && !full;
`ifdef P2M_UNKNOWN_TRAP_EN
   trap_state_t state, state_nxt;
   always_ff @(posedge CLK) state <= nRST ? RUN : state_nxt;
   // the bad head is never popped, so it keeps err_unknown high until reset
   always_comb begin
      state_nxt = state;
      err_evt = 1'b0;
      if (state == RUN && bad) begin
         state_nxt = TRAP;
         err_evt = 1'b1;
      end
   end
   assign pop = |ena;
`else
   assign err_evt = bad;
   assign pop = |ena || bad;
`endif
   always_ff @(posedge CLK) err_cnt <= nRST ? '0 : err_evt ? sat_inc(err_cnt) : err_cnt;
   assign bus.pipe_enq_rdy = !full;
   assign bus.method_ena = ena;
   assign bus.method_data = empty ? '0 : head[PAYLOAD_W-1:0];
   assign bus.err_unknown = bad;
   assign bus.err_count = err_cnt;
   assign bus.occupancy = count;
endmodule

// File: tb/tb_p2m_dispatch.sv
// tb_p2m_dispatch: randomized scoreboard bench for p2m_dispatch; expected dispatches come from a message queue model
module tb_p2m_dispatch;
   import p2m_pkg::*;
   localparam int NM = 2;
   localparam int SW = 16;
   localparam int PW = 128;
   localparam int DEPTH = 4;
   typedef enum {P_RDY, P_OCC, P_ECNT, P_EUNK, P_ENA} field_t;
   typedef struct {
      string name;
      field_t f;
      logic [31:0] want;
   } probe_t;
   logic CLK = 0;
   logic nRST = 1;
   always #5 CLK = ~CLK;
   p2m_if #(.NUM_METHODS(NM), .SEL_W(SW), .PAYLOAD_W(PW), .DEPTH(DEPTH)) bus();
   p2m_dispatch #(.NUM_METHODS(NM), .SEL_W(SW), .PAYLOAD_W(PW), .DEPTH(DEPTH)) dut (
      .CLK(CLK), .nRST(nRST), .bus(bus)
   );
   msg_t exp_q[$];
   probe_t probe_q[$];
   int n_chk = 0;
   int n_fail = 0;
   int exp_err = 0;
   bit trapped = 0;
   msg_t m;
   probe_t p;
   logic [159:0] act;

   task automatic chk(input string n, input logic [159:0] a, input logic [159:0] w);
      n_chk++;
      if (a !== w) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", n, a, w, $time);
      end
   endtask

   // monitor: every ENA or discard pulse consumes the oldest expected message
   always @(negedge CLK) begin
      if (nRST) chk("rst_no_ena", 160'(bus.method_ena), 160'(0));
      else begin
         if (bus.method_ena != '0) begin
            chk("ena_onehot_rdy", 160'($onehot(bus.method_ena) && (bus.method_ena & ~bus.method_rdy) == '0), 160'(1));
            if (exp_q.size() == 0) chk("unexpected_ena", 160'(bus.method_ena), 160'(0));
            else begin
               m = exp_q.pop_front();
               chk("disp_sel", 160'(bus.method_ena), 160'(NM'(1) << m.sel));
               chk("disp_data", 160'(bus.method_data), 160'(m.payload));
            end
         end
`ifndef P2M_UNKNOWN_TRAP_EN
         if (bus.err_unknown) begin
            chk("err_no_ena", 160'(bus.method_ena), 160'(0));
            if (exp_q.size() == 0) chk("unexpected_err", 160'(bus.err_unknown), 160'(0));
            else begin
               m = exp_q.pop_front();
               chk("err_order", 160'(int'(m.sel) >= NM), 160'(1));
            end
         end
`endif
      end
      while (probe_q.size() != 0) begin
         p = probe_q.pop_front();
         case (p.f)
            P_RDY: act = 160'(bus.pipe_enq_rdy);
            P_OCC: act = 160'(bus.occupancy);
            P_ECNT: act = 160'(bus.err_count);
            P_EUNK: act = 160'(bus.err_unknown);
            default: act = 160'(bus.method_ena);
         endcase
         chk(p.name, act, 160'(p.want));
      end
   end

   task automatic probe(input string n, input field_t f, input logic [31:0] w);
      probe_t t;
      t.name = n;
      t.f = f;
      t.want = w;
      probe_q.push_back(t);
   endtask

   task automatic cyc(input int n);
      repeat (n) @(posedge CLK);
      #1;
   endtask

   task automatic enq(input logic [SW-1:0] s, input logic [PW-1:0] pl);
      int n = 0;
      msg_t t;
      while (!bus.pipe_enq_rdy && n < 200) begin
         cyc(1);
         n++;
      end
      bus.pipe_enq_ena = 1;
      bus.pipe_enq_v = {s, pl};
      @(posedge CLK);
      t.sel = s;
      t.payload = pl;
`ifdef P2M_UNKNOWN_TRAP_EN
      if (int'(s) >= NM) begin
         if (!trapped) exp_err++;
         trapped = 1;
      end else exp_q.push_back(t);
`else
      exp_q.push_back(t);
      if (int'(s) >= NM) exp_err = exp_err < 65535 ? exp_err + 1 : 65535;
`endif
      #1;
      bus.pipe_enq_ena = 0;
   endtask

   task automatic drain(input string n);
      int k = 0;
      while (bus.occupancy != 0 && k < 100) begin
         cyc(1);
         k++;
      end
      probe(n, P_OCC, 0);
      cyc(1);
   endtask

   function automatic logic [PW-1:0] rp();
      return {$urandom(), $urandom(), $urandom(), $urandom()};
   endfunction

   function automatic logic [SW-1:0] rs();
      return SW'($urandom_range(0, NM - 1));
   endfunction

   initial begin
      bus.pipe_enq_ena = 0;
      bus.pipe_enq_v = '0;
      bus.method_rdy = '0;
      cyc(2);
      nRST = 0;
      probe("reset_rdy", P_RDY, 1);
      probe("reset_occ", P_OCC, 0);
      probe("reset_ecnt", P_ECNT, 0);
      probe("reset_eunk", P_EUNK, 0);
      probe("reset_ena", P_ENA, 0);
      cyc(1);
      bus.method_rdy = 2'b11;
      enq(0, 128'hAB);
      probe("lat_first_ena", P_ENA, 1);
      enq(1, 128'h1234);
      probe("lat_second_ena", P_ENA, 2);
      drain("basic_drain");
      bus.method_rdy = 2'b00;
      repeat (4) enq(rs(), rp());
      probe("full_rdy", P_RDY, 0);
      probe("full_occ", P_OCC, 4);
      cyc(1);
      bus.method_rdy = 2'b11;
      cyc(1);
      probe("pop_rdy", P_RDY, 1);
      probe("pop_occ", P_OCC, 3);
      enq(rs(), rp());
      drain("bp_drain");
      bus.method_rdy = 2'b01;
      enq(1, rp());
      enq(0, rp());
      cyc(3);
      probe("hol_ena", P_ENA, 0);
      probe("hol_occ", P_OCC, 2);
      cyc(1);
      bus.method_rdy = 2'b11;
      drain("hol_drain");
      bus.method_rdy = 2'b00;
      enq(rs(), 0);
      enq(rs(), 1);
      bus.method_rdy = 2'b11;
      for (int i = 2; i < 10; i++) begin
         enq(rs(), PW'(i));
         probe("simul_occ", P_OCC, 2);
      end
      drain("wrap_drain");
`ifndef P2M_UNKNOWN_TRAP_EN
      enq(0, rp());
      enq(7, rp());
      enq(1, rp());
      drain("unk_drain");
      probe("unk_ecnt", P_ECNT, exp_err);
      for (int i = 0; i < 65535; i++) enq(SW'($urandom_range(NM, 65535)), PW'(i));
      enq(rs(), rp());
      drain("sat_drain");
      probe("sat_ecnt", P_ECNT, exp_err);
      probe("sat_ecnt_max", P_ECNT, 32'hFFFF);
      cyc(1);
      bus.method_rdy = 2'b00;
      repeat (3) enq(rs(), rp());
      probe("pre_rst_occ", P_OCC, 3);
`else
      enq(9, rp());
      enq(0, rp());
      enq(1, rp());
      cyc(2);
      probe("trap_eunk", P_EUNK, 1);
      probe("trap_ecnt", P_ECNT, exp_err);
      probe("trap_occ", P_OCC, 3);
      cyc(3);
      probe("trap_eunk_held", P_EUNK, 1);
      probe("trap_ecnt_once", P_ECNT, 1);
      probe("trap_ena", P_ENA, 0);
`endif
      cyc(1);
      bus.method_rdy = 2'b11;
      nRST = 1;
      exp_q.delete();
      exp_err = 0;
      trapped = 0;
      cyc(1);
      nRST = 0;
      probe("post_rst_occ", P_OCC, 0);
      probe("post_rst_ecnt", P_ECNT, exp_err);
      probe("post_rst_eunk", P_EUNK, 0);
      probe("post_rst_rdy", P_RDY, 1);
      probe("post_rst_ena", P_ENA, 0);
      cyc(5);
      probe("idle_ena", P_ENA, 0);
      cyc(1);
      enq(rs(), rp());
      drain("final_drain");
      cyc(2);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule

// File: doc/p2m_dispatch.md
Name: p2m_dispatch

Overview:
- Parametrised pipe-to-method demultiplexer. Next generation of the generated per-interface P2M adapters.
- Accepts serialized request messages on a PipeIn-style enq handshake. Each message is a selector in the top SEL_W bits plus a payload.
- Buffers messages in a DEPTH-entry FIFO and dispatches each in order to one of NUM_METHODS method ports using ENA/RDY.
- Sits between the host-side transport and the user request interface. Replaces the hard-wired two-method combinational adapter.

Parameters:
- NUM_METHODS, 2, number of method ports (1..16).
- SEL_W, 16, selector field width in the message.
- PAYLOAD_W, 128, payload width below the selector.
- DEPTH, 4, FIFO entries (power of two, >=2).
- Derived: MSG_W = SEL_W + PAYLOAD_W; CNT_W = $clog2(DEPTH+1).

Ports:
- CLK  in  1  clock.
- nRST  in  1  reset. Synchronous, active-high. The codebase port name is kept; when 1 at a CLK edge the block resets.
- pipe_enq_ena  in  1  message valid/enqueue strobe. Only asserted when pipe_enq_rdy is 1.
- pipe_enq_v  in  MSG_W  message: [MSG_W-1:PAYLOAD_W] selector, [PAYLOAD_W-1:0] payload.
- pipe_enq_rdy  out  1  FIFO can accept.
- method_ena  out  NUM_METHODS  one-hot dispatch strobe.
- method_data  out  PAYLOAD_W  payload of the head message. Common to all methods.
- method_rdy  in  NUM_METHODS  per-method ready.
- err_unknown  out  1  one-cycle pulse when an out-of-range selector is discarded.
- err_count  out  16  saturating count of discarded messages.
- occupancy  out  CNT_W  current FIFO fill.

Behaviour:
- Reset (nRST=1 at edge):
  - FIFO pointers and count = 0; err_count = 0; err_unknown = 0; trap state cleared.
  - Effective next cycle: pipe_enq_rdy=1, method_ena=0, occupancy=0.
  - Reset mid-transfer discards all buffered messages. Nothing is dispatched in the reset cycle.
- Enqueue:
  - pipe_enq_rdy = (count < DEPTH).
  - When pipe_enq_ena is 1, pipe_enq_v is written at the tail on the CLK edge.
  - There is no bypass, so ready does not depend on same-cycle dequeue. When full, rdy=0 even if a pop occurs that cycle.
- Latency: minimum 1 cycle. A message enqueued at edge N can dispatch in the cycle after edge N.
- Head decode (combinational from FIFO head, valid when count>0): sel = head[MSG_W-1:PAYLOAD_W].
  - sel < NUM_METHODS: method_ena[sel] = method_rdy[sel]; all other bits 0. ENA never asserts without RDY.
    - Pop on the edge where method_ena is nonzero.
    - If method_rdy[sel]=0, the head stalls. Head-of-line blocking: later messages wait regardless of their targets' readiness.
  - sel >= NUM_METHODS: message is discarded.
    - Pop in one cycle; err_unknown=1 for that cycle.
    - err_count increments, saturating at 16'hFFFF.
    - No method_ena is asserted.
- method_data = head[PAYLOAD_W-1:0] whenever count>0. Otherwise don't-care; drive 0.
- Simultaneous enq and pop: count unchanged, both pointers advance.
- Pointers wrap modulo DEPTH. count distinguishes full from empty.
- occupancy = count (registered).
- Ordering: strict FIFO. At most one dispatch per cycle.

Optional Feature:
- Macro P2M_UNKNOWN_TRAP_EN.
- Defined: an unknown selector is not discarded.
  - The block enters TRAP: head is held, dispatch stops, err_unknown is held at 1 (level, not pulse).
  - err_count increments once on trap entry.
  - Enqueue continues until the FIFO is full.
  - TRAP exits only on reset.
- Undefined: discard-and-pulse behaviour as above. No trap state exists.

Decomposition:
- Shared package p2m_pkg:
  - selector/payload width localparams;
  - typedef for the message struct (sel, payload);
  - err counter width constant.
- One sub-module is natural: p2m_fifo (parametrised DEPTH x MSG_W sync FIFO with count, push/pop, full/empty).
- Decode, dispatch and error logic remain in p2m_dispatch.

Test Plan:
- Basic dispatch, NUM_METHODS=2, all rdy=1:
  - Stimulus: enq sel=0 payload=0x...00AB, then sel=1 payload=0x...1234.
  - Response: method_ena=01 with data 0xAB one cycle after the first enq, then ena=10 with data 0x1234 on the next cycle.
- Backpressure/full, DEPTH=4, method_rdy=00:
  - Stimulus: enq 5 messages.
  - Response: rdy drops after 4, occupancy=4. Raising rdy=11 drains the 4 in order, one per cycle, and rdy returns to 1 on the cycle after the first pop.
- Head-of-line blocking:
  - Stimulus: queue sel=1 then sel=0, with method_rdy=01.
  - Response: no ena until rdy[1]=1. Then ena=10, then ena=01.
- Unknown selector (trap disabled):
  - Stimulus: enq sel=7 between two valid messages.
  - Response: err_unknown pulses 1 cycle, err_count=1, surrounding messages dispatch in order. With err_count preloaded by 65535 bad messages, it stays at FFFF.
- Simultaneous enq/pop at count=2:
  - Response: occupancy stays 2. Pointer wrap verified across 10 consecutive messages with payloads 0..9, dispatched in order.
- Reset mid-stream:
  - Stimulus: 3 queued messages, assert nRST=1 for one cycle.
  - Response: occupancy=0, no ena afterwards, err_count=0. With P2M_UNKNOWN_TRAP_EN, TRAP entered on sel=9 is cleared by the reset.
